// File: rtl/ezp_tx_arbiter.sv
// ezp_tx_arbiter: round-robin packet arbiter feeding one EZPack UART TX path with an idle gap between packets.
// Define EZP_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module ezp_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_PD_LEN = 2,
  parameter int MAX_PKTLEN = MAX_PD_LEN + 5,
  parameter int GAP_CLKS   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ*8*MAX_PKTLEN-1:0] i_req_data,
  input  logic [N_REQ-1:0]              i_req_valid,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic [8*MAX_PKTLEN-1:0]       o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(N_REQ)-1:0]      o_grant_id,
  output logic                          o_busy
);
  localparam int PW = 8 * MAX_PKTLEN;
  localparam int IW = $clog2(N_REQ);
  localparam int GW = GAP_CLKS > 0 ? $clog2(GAP_CLKS + 1) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] base, win;
  logic found;
`ifdef EZP_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IW-1:0] ptr;
  assign base = ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (state == IDLE && found) ptr <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
`endif
  // Scan from the farthest offset down so the nearest valid requester after base wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (i_req_valid[(int'(base) + i) % N_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(base) + i) % N_REQ);
      end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = found ? SEND : IDLE;
      SEND:    state_n = i_ready ? (GAP_CLKS == 0 ? IDLE : GAP) : SEND;
      GAP:     state_n = gap_cnt == '0 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  assign o_req_ready = (!rst && state == IDLE && found) ? N_REQ'(1) << win : '0;
  assign o_valid     = state == SEND;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      o_data     <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
    end else begin
      state   <= state_n;
      o_busy  <= state_n != IDLE;
      gap_cnt <= state == SEND ? GW'(GAP_CLKS > 0 ? GAP_CLKS - 1 : 0) :
                 (state == GAP && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
      if (state == IDLE && found) begin
        o_data     <= i_req_data[win*PW +: PW];
        o_grant_id <= win;
      end
    end
endmodule
